q_accumulator: RTL and testbench

Output-side partial-sum accumulator that sits directly downstream of the MAC array. It takes the per-row result vector the array emits each cycle and sums successive K-tiles into a row-addressed accumulator buffer. When a tile is marked last, it pushes the final saturated sum into an output FIFO with a valid/ready handshake. The MAC array cannot be stalled, so the block reports FIFO pressure upstream through `almost_full` and flags any dropped result.

---
 rtl/q_accumulator.sv | 176 +++++++++++++++++
 tb/tb_q_accumulator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_accumulator.sv
// Partial-sum accumulator behind the MAC array: sums K-tiles per row address
// and emits finished, saturated sums through a first-word fall-through FIFO.
module q_accumulator #(
    parameter int unsigned SZI        = 8,
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          q_valid,
    input  logic                          q_first,
    input  logic                          q_last,
    input  logic [$clog2(DEPTH)-1:0]      q_addr,
    input  logic [SZI*IN_WIDTH-1:0]       q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SZI*ACC_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH)-1:0]      out_addr,
    output logic                          almost_full,
    output logic                          overflow,
    output logic                          saturated
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned Q_W    = SZI * IN_WIDTH;
    localparam int unsigned D_W    = SZI * ACC_WIDTH;
    localparam int unsigned SUM_W  = ACC_WIDTH + 1;
    localparam int unsigned FA_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = FA_W + 1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Pipeline state
    logic              s1_valid, s1_first, s1_last;
    logic [ADDR_W-1:0] s1_addr;
    logic [Q_W-1:0]    s1_q;
    logic              s2_valid, s2_first, s2_last;
    logic [ADDR_W-1:0] s2_addr;
    logic [Q_W-1:0]    s2_q;
    logic [D_W-1:0]    s2_acc;

    logic [D_W-1:0]    acc_mem [DEPTH];

    // Stage-2 arithmetic
    logic [D_W-1:0]              s2_sum;
    logic                        sum_sat;
    logic signed [IN_WIDTH-1:0]  q_lane;
    logic signed [ACC_WIDTH-1:0] a_lane;
    logic signed [SUM_W-1:0]     q_ext, a_ext, raw_sum;

    logic s2_write, fwd_hit;

    // FIFO state
    logic [D_W-1:0]    fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [FA_W-1:0]   wr_idx, rd_idx;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              push_c, pop_c, full_c, push_ok_c;

    assign s2_write = s2_valid && !s2_last;
    assign fwd_hit  = s2_write && (s2_addr == s1_addr);

    // Per-lane sign-extend, add and clamp to the signed accumulator range
    always_comb begin
        s2_sum  = '0;
        sum_sat = 1'b0;
        q_lane  = '0;
        a_lane  = '0;
        q_ext   = '0;
        a_ext   = '0;
        raw_sum = '0;
        for (int i = 0; i < int'(SZI); i++) begin
            q_lane  = s2_q[i*IN_WIDTH +: IN_WIDTH];
            a_lane  = s2_acc[i*ACC_WIDTH +: ACC_WIDTH];
            q_ext   = SUM_W'(q_lane);
            a_ext   = s2_first ? '0 : SUM_W'(a_lane);
            raw_sum = q_ext + a_ext;
            if (raw_sum[SUM_W-1] != raw_sum[SUM_W-2]) begin
                sum_sat = 1'b1;
                s2_sum[i*ACC_WIDTH +: ACC_WIDTH] = raw_sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
            end else begin
                s2_sum[i*ACC_WIDTH +: ACC_WIDTH] = raw_sum[ACC_WIDTH-1:0];
            end
        end
    end

    // S1 captures the beat; S2 captures it plus the stored sum, forwarding
    // the sum S2 is writing this edge so back-to-back tiles are not lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_addr   <= '0;
            s1_q      <= '0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_addr   <= '0;
            s2_q      <= '0;
            s2_acc    <= '0;
            saturated <= 1'b0;
        end else begin
            s1_valid  <= q_valid;
            s1_first  <= q_first;
            s1_last   <= q_last;
            s1_addr   <= q_addr;
            s1_q      <= q;
            s2_valid  <= s1_valid;
            s2_first  <= s1_first;
            s2_last   <= s1_last;
            s2_addr   <= s1_addr;
            s2_q      <= s1_q;
            s2_acc    <= fwd_hit ? s2_sum : acc_mem[s1_addr];
            saturated <= saturated | (s2_valid & sum_sat);
        end
    end

    // Accumulator storage has no reset and maps onto a RAM
    always_ff @(posedge clk) begin
        if (s2_write) begin
            acc_mem[s2_addr] <= s2_sum;
        end
    end

    assign push_c    = s2_valid && s2_last;
    assign pop_c     = out_valid && out_ready;
    assign full_c    = (count == CNT_W'(FIFO_DEPTH));
    assign push_ok_c = push_c && (!full_c || pop_c);

    always_comb begin
        count_nxt = count;
        if (push_ok_c && !pop_c) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push_ok_c && pop_c) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Output FIFO; a push into a full FIFO with a simultaneous pop reuses the head slot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
            wr_idx      <= '0;
            rd_idx      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok_c) begin
                fifo_data[wr_idx] <= s2_sum;
                fifo_addr[wr_idx] <= s2_addr;
                wr_idx            <= wr_idx + FA_W'(1);
            end
            if (pop_c) begin
                rd_idx <= rd_idx + FA_W'(1);
            end
            count       <= count_nxt;
            out_valid   <= (count_nxt != '0);
            almost_full <= (count_nxt >= CNT_W'(AF_LEVEL));
            overflow    <= overflow | (push_c & full_c & ~pop_c);
        end
    end

    assign out_data = fifo_data[rd_idx];
    assign out_addr = fifo_addr[rd_idx];

endmodule

// File: tb/tb_q_accumulator.sv
// Directed bench for q_accumulator: default build plus a 32-bit accumulator
// build sharing the same stimulus for the saturation cases.
module tb_q_accumulator;

    logic         clk = 1'b0;
    logic         resetn;
    logic         q_valid, q_first, q_last;
    logic [5:0]   q_addr;
    logic [255:0] q;
    logic         out_ready;

    logic         out_valid, almost_full, overflow, saturated;
    logic [319:0] out_data;
    logic [5:0]   out_addr;

    logic         sat_out_valid, sat_almost_full, sat_overflow, sat_saturated;
    logic [255:0] sat_out_data;
    logic [5:0]   sat_out_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0]   got_addr [$];
    logic [319:0] got_data [$];
    logic [255:0] got_sat  [$];

    int vec_a [8];

    always #5 clk = ~clk;

    q_accumulator u_dut (
        .clk(clk), .resetn(resetn),
        .q_valid(q_valid), .q_first(q_first), .q_last(q_last),
        .q_addr(q_addr), .q(q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .almost_full(almost_full), .overflow(overflow), .saturated(saturated)
    );

    q_accumulator #(.ACC_WIDTH(32)) u_sat (
        .clk(clk), .resetn(resetn),
        .q_valid(q_valid), .q_first(q_first), .q_last(q_last),
        .q_addr(q_addr), .q(q),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_data(sat_out_data), .out_addr(sat_out_addr),
        .almost_full(sat_almost_full), .overflow(sat_overflow), .saturated(sat_saturated)
    );

    // Record every accepted output beat
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            got_addr.push_back(out_addr);
            got_data.push_back(out_data);
            got_sat.push_back(sat_out_data);
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pack_q(input int v [8]);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = v[i];
        return r;
    endfunction

    function automatic logic [319:0] pack_acc(input int v [8]);
        logic [319:0] r;
        for (int i = 0; i < 8; i++) r[i*40 +: 40] = 40'(v[i]);
        return r;
    endfunction

    function automatic logic [255:0] all_q(input int v);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [319:0] all_acc(input int v);
        logic [319:0] r;
        for (int i = 0; i < 8; i++) r[i*40 +: 40] = 40'(v);
        return r;
    endfunction

    task automatic send(input logic first, input logic last, input logic [5:0] addr,
                        input logic [255:0] qv);
        @(posedge clk); #1;
        q_valid = 1'b1;
        q_first = first;
        q_last  = last;
        q_addr  = addr;
        q       = qv;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        q_valid = 1'b0;
        q_first = 1'b0;
        q_last  = 1'b0;
    endtask

    task automatic clear_got();
        got_addr.delete();
        got_data.delete();
        got_sat.delete();
    endtask

    initial begin
        resetn    = 1'b0;
        q_valid   = 1'b0;
        q_first   = 1'b0;
        q_last    = 1'b0;
        q_addr    = '0;
        q         = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_saturated", saturated, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Single tile with mixed-sign lanes, latency check
        vec_a = '{1, -2, 3, -4, 5, -6, 7, -8};
        send(1'b1, 1'b1, 6'd5, pack_q(vec_a));
        idle();
        @(negedge clk);
        check("t1_valid_n0", out_valid, 0);
        @(negedge clk);
        check("t1_valid_n1", out_valid, 0);
        @(negedge clk);
        check("t1_valid_n2", out_valid, 1);
        check("t1_data", out_data, pack_acc(vec_a));
        check("t1_addr", out_addr, 5);
        repeat (3) @(posedge clk);
        check("t1_count", got_data.size(), 1);
        #1 clear_got();

        // Three back-to-back tiles to one address exercise forwarding
        send(1'b1, 1'b0, 6'd2, all_q(10));
        send(1'b0, 1'b0, 6'd2, all_q(20));
        send(1'b0, 1'b1, 6'd2, all_q(-5));
        idle();
        repeat (6) @(posedge clk);
        check("t2_count", got_data.size(), 1);
        if (got_data.size() == 1) begin
            check("t2_data", got_data[0], all_acc(25));
            check("t2_addr", got_addr[0], 2);
        end
        #1 clear_got();

        // Interleaved addresses
        send(1'b1, 1'b0, 6'd0, all_q(1));
        send(1'b1, 1'b0, 6'd1, all_q(100));
        send(1'b0, 1'b1, 6'd0, all_q(2));
        send(1'b0, 1'b1, 6'd1, all_q(200));
        idle();
        repeat (6) @(posedge clk);
        check("t3_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("t3_addr0", got_addr[0], 0);
            check("t3_data0", got_data[0], all_acc(3));
            check("t3_addr1", got_addr[1], 1);
            check("t3_data1", got_data[1], all_acc(300));
        end
        #1 clear_got();

        // Saturation: lanes 0-3 push past max, lanes 4-7 past min
        check("t4_sat_pre", saturated, 0);
        check("t4_sat32_pre", sat_saturated, 0);
        send(1'b1, 1'b0, 6'd9, {{4{32'h8000_0000}}, {4{32'h7FFF_FFFF}}});
        send(1'b0, 1'b1, 6'd9, {{4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}});
        idle();
        repeat (6) @(posedge clk);
        check("t4_count", got_data.size(), 1);
        if (got_data.size() == 1) begin
            check("t4_sat32_data", got_sat[0], {{4{32'h8000_0000}}, {4{32'h7FFF_FFFF}}});
            check("t4_wide_data", got_data[0], {{4{40'hFF_7FFF_FFFF}}, {4{40'h00_8000_0000}}});
        end
        check("t4_sat32_flag", sat_saturated, 1);
        check("t4_wide_flag", saturated, 0);
        repeat (4) @(posedge clk);
        check("t4_sat32_sticky", sat_saturated, 1);
        #1 clear_got();

        // Backpressure: nine single tiles into an eight-deep FIFO
        out_ready = 1'b0;
        for (int j = 0; j < 9; j++) begin
            send(1'b1, 1'b1, 6'(j), all_q(j + 50));
            idle();
            repeat (2) @(posedge clk);
            @(negedge clk);
            check($sformatf("t5_af_%0d", j), almost_full, (j + 1 >= 6) ? 1 : 0);
            check($sformatf("t5_ovf_%0d", j), overflow, (j + 1 > 8) ? 1 : 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (12) @(posedge clk);
        check("t5_count", got_data.size(), 8);
        for (int k = 0; k < 8 && k < got_data.size(); k++) begin
            check($sformatf("t5_addr_%0d", k), got_addr[k], k);
            check($sformatf("t5_data_%0d", k), got_data[k], all_acc(k + 50));
        end
        check("t5_af_drained", almost_full, 0);
        check("t5_ovf_sticky", overflow, 1);
        #1 clear_got();

        // Reset while three beats are in flight
        send(1'b1, 1'b1, 6'd10, all_q(1));
        send(1'b1, 1'b1, 6'd11, all_q(2));
        send(1'b1, 1'b1, 6'd12, all_q(3));
        @(posedge clk); #1;
        q_valid = 1'b0;
        check("t6_valid_pre", out_valid, 1);
        #1 resetn = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data", out_data, 0);
        check("t6_out_addr", out_addr, 0);
        check("t6_almost_full", almost_full, 0);
        check("t6_overflow", overflow, 0);
        check("t6_sat32", sat_saturated, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_no_output", got_data.size(), 0);
        check("t6_valid_post", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
